// File: rtl/riscv_aes_pkg.sv
// riscv_aes_pkg: shared types and constants for the AES-128 cipher sequencer.
package riscv_aes_pkg;
    localparam int AES_WORD_W      = 32;
    localparam int AES_BLK_W       = 128;
    localparam int AES_WORDS       = 4;
    localparam int AES_DEF_LATENCY = 10;
    localparam logic SEL_DATA = 1'b0;
    localparam logic SEL_KEY  = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} aes_ctrl_state_e;
endpackage

// File: rtl/riscv_aes_word_bank.sv
// riscv_aes_word_bank: 128-bit operand register assembled from 32-bit words with a per-word valid mask.
module riscv_aes_word_bank
    import riscv_aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [1:0]           idx,
    input  logic [AES_WORD_W-1:0] wdata,
    input  logic                 clr,
    input  logic                 freeze,
    output logic [AES_BLK_W-1:0] data,
    output logic [AES_WORDS-1:0] mask,
    output logic [AES_WORDS-1:0] mask_next
);
    logic wr;

    assign wr = wr_en & ~freeze;
    // Mask as it will be after this cycle's write; lets go_i see a same-cycle last word.
    assign mask_next = wr ? (mask | (4'b1000 >> idx)) : mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            mask <= '0;
        end else begin
            mask <= clr ? '0 : mask_next;
            if (wr)
                data[(AES_WORDS-1-int'(idx))*AES_WORD_W +: AES_WORD_W] <= wdata;
        end
    end
endmodule

// File: rtl/riscv_aes_cipher_ctrl.sv
// riscv_aes_cipher_ctrl: operand assembly, start/latency sequencing and result handshake for the AES-128 pipeline.
// Define AES_KEY_RETAIN_EN to keep the key bank valid across result handshakes.
module riscv_aes_cipher_ctrl
    import riscv_aes_pkg::*;
#(
    parameter int CIPHER_LATENCY = AES_DEF_LATENCY,
    parameter int CNT_W          = $clog2(CIPHER_LATENCY + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic                  wr_sel_i,
    input  logic [1:0]            wr_idx_i,
    input  logic [AES_WORD_W-1:0] wr_data_i,
    input  logic                  go_i,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [AES_BLK_W-1:0]  datain_o,
    output logic [AES_BLK_W-1:0]  key_o,
    output logic                  start_aes_cipher_o,
    input  logic [AES_BLK_W-1:0]  cipher_dataout_i,
    output logic                  res_valid_o,
    output logic [AES_BLK_W-1:0]  res_data_o,
    input  logic                  res_ready_i
);
    aes_ctrl_state_e      state;
    logic [CNT_W-1:0]     cnt;
    logic [AES_WORDS-1:0] data_mask, key_mask, data_mask_nx, key_mask_nx;
    logic                 idle, wr_acc, go_ok, hs, key_clr;

    assign idle   = state == IDLE;
    assign wr_acc = wr_valid_i & wr_ready_o & idle;
    assign go_ok  = go_i & idle & (&data_mask_nx) & (&key_mask_nx);
    assign hs     = (state == DONE) & res_valid_o & res_ready_i;
`ifdef AES_KEY_RETAIN_EN
    assign key_clr = 1'b0;
`else
    assign key_clr = hs;
`endif

    riscv_aes_word_bank u_data_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_acc & (wr_sel_i == SEL_DATA)),
        .idx       (wr_idx_i),
        .wdata     (wr_data_i),
        .clr       (hs),
        .freeze    (~idle),
        .data      (datain_o),
        .mask      (data_mask),
        .mask_next (data_mask_nx)
    );

    riscv_aes_word_bank u_key_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_acc & (wr_sel_i == SEL_KEY)),
        .idx       (wr_idx_i),
        .wdata     (wr_data_i),
        .clr       (key_clr),
        .freeze    (~idle),
        .data      (key_o),
        .mask      (key_mask),
        .mask_next (key_mask_nx)
    );

    // The counter is loaded on the go edge so the capture lands CIPHER_LATENCY edges after start rises,
    // which for a latency of 1 means capturing straight out of ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            wr_ready_o         <= 1'b0;
            busy_o             <= 1'b0;
            err_o              <= 1'b0;
            start_aes_cipher_o <= 1'b0;
            res_valid_o        <= 1'b0;
            res_data_o         <= '0;
        end else begin
            start_aes_cipher_o <= 1'b0;
            err_o              <= 1'b0;
            case (state)
                IDLE: begin
                    state              <= go_ok ? ISSUE : IDLE;
                    wr_ready_o         <= ~go_ok;
                    busy_o             <= go_ok;
                    start_aes_cipher_o <= go_ok;
                    err_o              <= go_i & ~go_ok;
                    if (go_ok)
                        cnt <= CNT_W'(CIPHER_LATENCY - 1);
                end
                ISSUE, WAIT: begin
                    if (cnt == '0) begin
                        res_data_o  <= cipher_dataout_i;
                        res_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= WAIT;
                    end
                end
                DONE: begin
                    if (hs) begin
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        wr_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/riscv_aes_cipher_ctrl.md
Name: riscv_aes_cipher_ctrl

Overview:
Upstream and downstream sequencer for the unrolled AES-128 cipher pipeline.
- Accepts plaintext and key as 32-bit word writes from the RISC-V side and assembles them into 128-bit operands.
- Drives datain/key/start into the cipher and holds them stable for the pipeline latency.
- Captures the 128-bit ciphertext and presents it through a valid/ready result port.

Parameters:
- CIPHER_LATENCY, default 10: cycles from start pulse to valid cipher dataout; must be at least 1.
- CNT_W, default $clog2(CIPHER_LATENCY+1): latency counter width (derived).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid_i  in  1  operand word write request
- wr_ready_o  out  1  write accepted when high
- wr_sel_i  in  1  0 = data bank, 1 = key bank
- wr_idx_i  in  2  word index; 0 maps to [127:96], 3 maps to [31:0]
- wr_data_i  in  32  operand word
- go_i  in  1  start-encryption request (single-cycle sample)
- busy_o  out  1  high in ISSUE, WAIT, DONE
- err_o  out  1  one-cycle pulse on a rejected go
- datain_o  out  128  to cipher datain
- key_o  out  128  to cipher key
- start_aes_cipher_o  out  1  one-cycle start pulse to cipher
- cipher_dataout_i  in  128  from cipher dataout
- res_valid_o  out  1  result available
- res_data_o  out  128  captured ciphertext
- res_ready_i  in  1  result consumed

Behaviour:
Reset values:
- All outputs reset to 0.
- State resets to IDLE.
- Both 4-bit word-valid masks reset to 0.

Reset interaction:
- rst_n assertion mid-operation aborts immediately.
- No result is emitted after release.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - wr_ready_o = 1.
  - An accepted write stores the word and sets the mask bit.
  - A rewrite of the same index overwrites the word; the mask bit stays set.
- IDLE and go_i:
  - go_i is evaluated against the masks including any same-cycle write.
  - If both masks are 4'hF, go to ISSUE.
  - Otherwise stay in IDLE and pulse err_o.
- ISSUE (1 cycle):
  - start_aes_cipher_o = 1.
  - Counter loads CIPHER_LATENCY-1.
  - Go to WAIT.
- WAIT:
  - Counter decrements by 1 each cycle.
  - When the counter is 0, capture cipher_dataout_i into res_data_o, set res_valid_o, and go to DONE.
  - Timing: with start at cycle T, capture is at edge T+CIPHER_LATENCY.
- DONE:
  - res_valid_o held.
  - On res_valid_o & res_ready_i: clear res_valid_o, clear masks, and return to IDLE.
- Outside IDLE:
  - wr_ready_o = 0; writes are ignored, not queued.
  - go_i is ignored, with no err_o pulse.

Operand and result stability:
- datain_o and key_o always reflect the banks.
- The banks are frozen from ISSUE through DONE.
- res_data_o holds its value after a handshake until the next capture.

Optional Feature:
AES_KEY_RETAIN_EN
- Defined:
  - The key mask is not cleared on result handshake; only the data mask clears.
  - Back-to-back blocks under one key need only 4 data writes.
  - A key rewrite is still allowed in IDLE.
- Undefined: both masks clear on the handshake.

Decomposition:
Package riscv_aes_pkg:
- State enum aes_ctrl_state_e.
- Localparams AES_WORD_W=32, AES_BLK_W=128, AES_WORDS=4.
- AES_DEF_LATENCY=10.
- Bank select constants SEL_DATA=0, SEL_KEY=1.

Sub-module riscv_aes_word_bank:
- 128-bit register plus 4-bit valid mask with word-indexed write, clear and freeze inputs.
- Instantiated twice (data, key).

Test Plan:
- FIPS-197 C.1 vector through the real cipher:
  - Writes: data 00112233/44556677/8899aabb/ccddeeff, key 00010203/04050607/08090a0b/0c0d0e0f, then go.
  - Required: start pulse for exactly one cycle.
  - Required: res_data_o = 69c4e0d86a7b0430d8cdb78070b4c55a at exactly start+10 cycles.
- go with key word 2 missing:
  - Required: err_o pulses once, state stays IDLE, no start pulse.
  - Then write word 2 and go again; the result is correct.
- Writes and go during WAIT:
  - Required: wr_ready_o = 0, datain_o/key_o unchanged, no err_o, result unaffected.
- res_ready_i held low for 20 cycles in DONE:
  - Required: res_valid_o and res_data_o stable.
  - After handshake: IDLE, masks 0, or the key mask stays F with AES_KEY_RETAIN_EN.
- rst_n pulsed low during WAIT at cycle start+4:
  - Required: all outputs 0 immediately, no res_valid_o afterwards.
- Last word written in the same cycle as go_i:
  - Required: go accepted, ISSUE on the next cycle.
  - Repeat with CIPHER_LATENCY=1: capture at start+1.
